// File: rtl/dst_pkg.sv
// Shared constants and state encoding for the dst_buf drain path.
package dst_pkg;

    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);
    localparam int FD    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2
    } drain_st_t;

endpackage

// File: rtl/dst_skid_fifo.sv
// Small synchronous FIFO between dst_buf reads and the output stream.
// Push and pop may coincide even when full; the head is read before the write lands.
module dst_skid_fifo #(
    parameter int W = 33,
    parameter int D = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [W-1:0]         push_data,
    input  logic                 pop,
    output logic [W-1:0]         pop_data,
    output logic [$clog2(D):0]   count,
    output logic                 empty
);

    localparam int PW = $clog2(D);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    logic [W-1:0] mem [D];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= push_data;
    end

    assign count    = wr_ptr - rd_ptr;
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/dst_drain_ctrl.sv
// Drains finished ping-pong banks of dst_buf, in address order, onto a valid/ready stream.
// Reads are credit-limited so the output FIFO can never overflow.
module dst_drain_ctrl
    import dst_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          out_fin,
    output logic          wr_bank,
    output logic          wr_stall,
    output logic          ovf,
    output logic          rd_en,
    output logic [AW:0]   rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          drain_busy,
    output logic          drain_fin
);

    localparam int CW = $clog2(FD);
    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);
    localparam logic [AW-1:0] CNT_ONE   = AW'(1);
    localparam logic [CW+1:0] CREDITS   = (CW+2)'(FD);

    drain_st_t     state;
    logic [AW-1:0] cnt;
    logic          rd_bank;
    logic [1:0]    full;
    logic [1:0]    full_n;

    logic          vld_p1;
    logic          last_p1;

    logic [CW:0]   fifo_count;
    logic          fifo_empty;
    logic [DW:0]   head;
    logic          pop;
    logic          credit_ok;
    logic          accept_last;

    assign credit_ok   = ((CW+2)'(fifo_count) + (CW+2)'(vld_p1)) < CREDITS;
    assign rd_en       = (state == ISSUE) && credit_ok;
    assign rd_addr     = rd_en ? {rd_bank, cnt} : '0;

    assign m_valid     = !fifo_empty;
    assign m_data      = m_valid ? head[DW-1:0] : '0;
    assign m_last      = m_valid & head[DW];
    assign pop         = m_valid & m_ready;
    assign accept_last = pop & m_last & (state == FLUSH);

    assign wr_stall    = &full;

    // p1: read data returns this stage; the last-word tag travels with it.
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= rd_en;
    end

    always_ff @(posedge clk) begin
        last_p1 <= (cnt == LAST_WORD);
    end

    dst_skid_fifo #(
        .W (DW + 1),
        .D (FD)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_p1),
        .push_data ({last_p1, rd_data}),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // A drain completing and a new block arriving may hit the same edge; both take effect.
    always_comb begin
        full_n = full;
        if (accept_last)         full_n[rd_bank] = 1'b0;
        if (out_fin && !wr_stall) full_n[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            full <= full_n;
            if (out_fin) begin
                if (wr_stall) ovf     <= 1'b1;
                else          wr_bank <= ~wr_bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rd_bank    <= 1'b0;
            drain_busy <= 1'b0;
            drain_fin  <= 1'b0;
        end else begin
            drain_fin <= 1'b0;
            case (state)
                IDLE: begin
                    if (full[rd_bank]) begin
                        state      <= ISSUE;
                        cnt        <= '0;
                        drain_busy <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (rd_en) begin
                        cnt <= cnt + CNT_ONE;
                        if (cnt == LAST_WORD) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (accept_last) begin
                        drain_fin  <= 1'b1;
                        rd_bank    <= ~rd_bank;
                        drain_busy <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dst_drain_ctrl.sv
// Scenario bench for dst_drain_ctrl: a dst_buf memory model, a block-level
// scoreboard of expected stream beats, and one task per scenario.
module tb_dst_drain_ctrl;
    import dst_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          out_fin;
    logic          wr_bank;
    logic          wr_stall;
    logic          ovf;
    logic          rd_en;
    logic [AW:0]   rd_addr;
    logic [DW-1:0] rd_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          drain_busy;
    logic          drain_fin;

    dst_drain_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .out_fin    (out_fin),
        .wr_bank    (wr_bank),
        .wr_stall   (wr_stall),
        .ovf        (ovf),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .drain_busy (drain_busy),
        .drain_fin  (drain_fin)
    );

    always #5 clk = ~clk;

    // dst_buf: one-cycle read latency
    logic [DW-1:0] mem [2*DEPTH];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t exp_q[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    pending = 0;
    int    m_wr_bank = 0;
    int    blk_beats = 0;
    int    total_beats = 0;
    int    fin_seen = 0;
    int    outstanding = 0;
    int    rmode = 0;
    bit    pending_fin = 0;
    bit    prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    // m_ready pattern generator: 0 always ready, 1 pattern 1,0,0, 2 random, 3 never ready
    initial begin
        int ph;
        ph = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = (ph == 0);
                2:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
            ph = (ph + 1) % 3;
        end
    end

    // Stream scoreboard
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            prev_stall  = 0;
            pending_fin = 0;
        end else begin
            n_chk++;
            if (drain_fin !== pending_fin) begin
                n_fail++;
                $display("FAIL drain_fin_timing: got %0b want %0b at %0t", drain_fin, pending_fin, $time);
            end
            if (drain_fin) fin_seen++;
            pending_fin = 0;
            if (prev_stall) begin
                n_chk++;
                if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
                    n_fail++;
                    $display("FAIL hold_stable: got v=%0b d=%h l=%0b want v=1 d=%h l=%0b", m_valid, m_data, m_last, prev_data, prev_last);
                end
            end
            if (rd_en) outstanding++;
            if (m_valid && m_ready) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat_unexpected: got d=%h l=%0b want no beat", m_data, m_last);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e.d || m_last !== e.l) begin
                        n_fail++;
                        $display("FAIL beat_data: got d=%h l=%0b want d=%h l=%0b", m_data, m_last, e.d, e.l);
                    end
                    if (e.l) begin
                        pending_fin = 1;
                        pending--;
                        blk_beats = -1;
                    end
                end
                outstanding--;
                total_beats++;
                blk_beats++;
            end
            n_chk++;
            if (outstanding > FD) begin
                n_fail++;
                $display("FAIL read_credit: got %0d outstanding want <= %0d", outstanding, FD);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    // Fills the producer's bank (kind 0: word index, 1: random) and pulses out_fin for one cycle.
    task automatic do_fin(input int kind);
        beat_t b;
        if (pending < 2) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[m_wr_bank*DEPTH + w] = (kind == 0) ? DW'(w) : DW'($urandom);
                b.d = mem[m_wr_bank*DEPTH + w];
                b.l = (w == DEPTH - 1);
                exp_q.push_back(b);
            end
            m_wr_bank = 1 - m_wr_bank;
            pending++;
        end
        out_fin = 1'b1;
        @(posedge clk);
        #1 out_fin = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            #1;
            guard++;
        end while (!(exp_q.size() == 0 && pending == 0 && !pending_fin && drain_busy == 1'b0) && guard < 5000);
        n_chk++;
        if (guard >= 5000) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d beats left want 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_fin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({wr_bank, wr_stall, ovf, rd_en, rd_addr, m_valid, m_data, m_last, drain_busy, drain_fin} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wb=%0b st=%0b ovf=%0b rd=%0b a=%h v=%0b d=%h l=%0b busy=%0b fin=%0b want all 0",
                     wr_bank, wr_stall, ovf, rd_en, rd_addr, m_valid, m_data, m_last, drain_busy, drain_fin);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single_block();
        int lat;
        int nv;
        rmode = 0;
        @(posedge clk);
        #1;
        do_fin(0);
        // first negedge after return is the cycle in which full is set
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!m_valid && lat < 20);
        n_chk++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL first_valid_latency: got %0d want 4 (3 cycles after full)", lat);
        end
        nv = (m_valid && m_ready) ? 1 : 0;
        repeat (DEPTH - 1) begin
            @(negedge clk);
            if (m_valid && m_ready) nv++;
        end
        n_chk++;
        if (nv !== DEPTH) begin
            n_fail++;
            $display("FAIL consecutive_beats: got %0d want %0d", nv, DEPTH);
        end
        @(negedge clk);
        n_chk++;
        if (drain_fin !== 1'b1 || drain_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_fin: got fin=%0b busy=%0b want fin=1 busy=0", drain_fin, drain_busy);
        end
        wait_idle();
    endtask

    task automatic test_backpressure();
        int b0;
        int f0;
        b0 = total_beats;
        f0 = fin_seen;
        rmode = 1;
        do_fin(1);
        wait_idle();
        n_chk++;
        if (total_beats - b0 !== DEPTH || fin_seen - f0 !== 1) begin
            n_fail++;
            $display("FAIL backpressure_count: got beats=%0d fins=%0d want %0d and 1", total_beats - b0, fin_seen - f0, DEPTH);
        end
    endtask

    task automatic test_ping_pong();
        int  guard;
        int  f0;
        bit  stall_bad;
        f0 = fin_seen;
        rmode = 2;
        @(posedge clk);
        #1;
        do_fin(1);
        do_fin(1);
        @(negedge clk);
        n_chk++;
        if (wr_stall !== 1'b1 || wr_bank !== 1'(m_wr_bank)) begin
            n_fail++;
            $display("FAIL pingpong_stall: got st=%0b wb=%0b want st=1 wb=%0d", wr_stall, wr_bank, m_wr_bank);
        end
        guard = 0;
        stall_bad = 0;
        while (drain_fin !== 1'b1 && guard < 3000) begin
            if (wr_stall !== 1'b1) stall_bad = 1;
            @(negedge clk);
            guard++;
        end
        n_chk++;
        if (guard >= 3000 || stall_bad) begin
            n_fail++;
            $display("FAIL pingpong_first_drain: got timeout=%0b early_release=%0b want 0 0", guard >= 3000, stall_bad);
        end
        @(negedge clk);
        n_chk++;
        if (wr_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL pingpong_release: got st=%0b want 0", wr_stall);
        end
        wait_idle();
        n_chk++;
        if (fin_seen - f0 !== 2) begin
            n_fail++;
            $display("FAIL pingpong_fins: got %0d want 2", fin_seen - f0);
        end
    endtask

    task automatic test_overflow();
        int b0;
        int f0;
        b0 = total_beats;
        f0 = fin_seen;
        n_chk++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_initial: got %0b want 0", ovf);
        end
        rmode = 3;
        @(posedge clk);
        #1;
        do_fin(1);
        do_fin(1);
        do_fin(1);
        @(negedge clk);
        n_chk++;
        if (ovf !== 1'b1 || wr_bank !== 1'(m_wr_bank) || wr_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got ovf=%0b wb=%0b st=%0b want 1 %0d 1", ovf, wr_bank, wr_stall, m_wr_bank);
        end
        repeat (10) @(negedge clk);
        n_chk++;
        if (ovf !== 1'b1 || wr_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_hold: got ovf=%0b st=%0b want 1 1", ovf, wr_stall);
        end
        rmode = 2;
        wait_idle();
        n_chk++;
        if (ovf !== 1'b1 || total_beats - b0 !== 2*DEPTH || fin_seen - f0 !== 2) begin
            n_fail++;
            $display("FAIL ovf_drain: got ovf=%0b beats=%0d fins=%0d want 1 %0d 2", ovf, total_beats - b0, fin_seen - f0, 2*DEPTH);
        end
    endtask

    task automatic test_coincident();
        int guard;
        int nb;
        int f0;
        f0 = fin_seen;
        rmode = 0;
        do_fin(1);
        guard = 0;
        do begin
            @(negedge clk);
            #1;
            guard++;
        end while (!(m_valid && m_last) && guard < 500);
        // out_fin lands on the same edge that accepts the m_last beat
        nb = m_wr_bank;
        do_fin(1);
        @(negedge clk);
        n_chk++;
        if (drain_fin !== 1'b1 || drain_busy !== 1'b0 || wr_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL coincide_fin: got fin=%0b busy=%0b st=%0b want 1 0 0", drain_fin, drain_busy, wr_stall);
        end
        @(negedge clk);
        n_chk++;
        if (drain_busy !== 1'b1 || rd_en !== 1'b1 || rd_addr !== (AW+1)'(nb*DEPTH)) begin
            n_fail++;
            $display("FAIL coincide_restart: got busy=%0b rd=%0b a=%h want 1 1 %h", drain_busy, rd_en, rd_addr, (AW+1)'(nb*DEPTH));
        end
        guard = 0;
        do begin
            @(negedge clk);
            #1;
            guard++;
        end while (drain_fin !== 1'b1 && guard < 500);
        // out_fin during the drain_fin cycle itself
        do_fin(1);
        wait_idle();
        n_chk++;
        if (fin_seen - f0 !== 3) begin
            n_fail++;
            $display("FAIL coincide_fins: got %0d want 3", fin_seen - f0);
        end
    endtask

    task automatic test_reset_mid_drain();
        int guard;
        rmode = 0;
        do_fin(1);
        guard = 0;
        do begin
            @(negedge clk);
            #1;
            guard++;
        end while (blk_beats != 20 && guard < 500);
        rst = 1'b1;
        exp_q.delete();
        pending = 0;
        m_wr_bank = 0;
        blk_beats = 0;
        outstanding = 0;
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({wr_bank, wr_stall, ovf, rd_en, rd_addr, m_valid, m_data, m_last, drain_busy, drain_fin} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got wb=%0b st=%0b ovf=%0b rd=%0b a=%h v=%0b d=%h l=%0b busy=%0b fin=%0b want all 0",
                     wr_bank, wr_stall, ovf, rd_en, rd_addr, m_valid, m_data, m_last, drain_busy, drain_fin);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        do_fin(1);
        guard = 0;
        while (rd_en !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_chk++;
        if (rd_en !== 1'b1 || rd_addr !== '0) begin
            n_fail++;
            $display("FAIL midreset_restart: got rd=%0b a=%h want 1 0", rd_en, rd_addr);
        end
        wait_idle();
    endtask

    task automatic test_random();
        int guard;
        int f0;
        f0 = fin_seen;
        rmode = 2;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 40)) @(posedge clk);
            #1;
            guard = 0;
            while (pending >= 2 && guard < 3000) begin
                @(posedge clk);
                #1;
                guard++;
            end
            do_fin(1);
        end
        wait_idle();
        n_chk++;
        if (fin_seen - f0 !== 8) begin
            n_fail++;
            $display("FAIL random_fins: got %0d want 8", fin_seen - f0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_block();
        test_backpressure();
        test_ping_pong();
        test_overflow();
        test_coincident();
        test_reset_mid_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
